// File: rtl/conv_mc_acc.sv
// Multi-channel 3x3 convolution accumulator: one window/weight beat per input
// channel, bias folded in on channel 0, result held until downstream accepts it.
// Optional build macro CONV_MC_RELU_EN clamps negative final sums to zero.
module conv_mc_acc #(
  parameter int DATA_W = 8,
  parameter int KERNEL = 9,
  parameter int IN_CH  = 3,
  parameter int ACC_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [KERNEL*DATA_W-1:0] win_i,
  input  logic [KERNEL*DATA_W-1:0] wgt_i,
  input  logic [ACC_W-1:0]         bias_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ACC_W-1:0]         result_o,
  output logic [7:0]               ch_idx_o
);

  localparam int          PROD_W  = 2 * DATA_W + 1;
  localparam logic [7:0]  LAST_CH = 8'(IN_CH - 1);

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] result_q;
  logic [7:0]       ch_idx_q;

  logic signed [DATA_W:0]   pix_s;
  logic signed [DATA_W-1:0] wgt_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  dot_acc;

  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] final_sum;
  logic             beat_acc;
  logic             last_beat;

  // Dot product. Each full-precision product is folded straight into ACC_W
  // bits: since all accumulation wraps modulo 2^ACC_W, truncating early gives
  // the same bits as sign-extending a wider sum and truncating later.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop
    // assignment, so synthesis never has a path that keeps an old value (latch).
    pix_s   = '0;
    wgt_s   = '0;
    prod_s  = '0;
    dot_acc = '0;
    for (int k = 0; k < KERNEL; k++) begin
      pix_s   = {1'b0, win_i[(KERNEL-1-k)*DATA_W +: DATA_W]};
      wgt_s   = wgt_i[(KERNEL-1-k)*DATA_W +: DATA_W];
      prod_s  = PROD_W'(pix_s) * PROD_W'(wgt_s);
      dot_acc = dot_acc + ACC_W'(prod_s);
    end
  end

  assign beat_acc  = in_valid_i && in_ready_o;
  assign last_beat = beat_acc && (ch_idx_q == LAST_CH);
  assign acc_base  = (ch_idx_q == 8'd0) ? bias_i : acc_q;
  assign acc_sum   = acc_base + dot_acc;

`ifdef CONV_MC_RELU_EN
  assign final_sum = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
  assign final_sum = acc_sum;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (last_beat)   state_d = ST_OUT;
      ST_OUT:  if (out_ready_i) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Outputs decoded from the registered state only; out_ready_i never
  // reaches in_ready_o combinationally.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      ST_ACC:  in_ready_o  = 1'b1;
      ST_OUT:  out_valid_o = 1'b1;
      default: in_ready_o  = 1'b0;
    endcase
  end

  // Accumulator, channel counter and result register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
      ch_idx_q <= '0;
    end else if (beat_acc) begin
      acc_q <= acc_sum;
      if (last_beat) begin
        ch_idx_q <= '0;
        result_q <= final_sum;
      end else begin
        ch_idx_q <= ch_idx_q + 8'd1;
      end
    end
  end

  assign result_o = result_q;
  assign ch_idx_o = ch_idx_q;

  // A stalled result must not move.
  a_hold_result : assert property (
    @(posedge clk_i) disable iff (!rst_n)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(result_o))
  );

endmodule

// File: tb/tb_conv_mc_acc.sv
// Scoreboard bench for conv_mc_acc: stimulus pushes model results into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_conv_mc_acc;

  localparam int DATA_W = 8;
  localparam int KERNEL = 9;
  localparam int IN_CH  = 3;
  localparam int ACC_W  = 32;
  localparam int KW     = KERNEL * DATA_W;
`ifdef CONV_MC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [KW-1:0]    win, wgt;
  logic [ACC_W-1:0] bias, result;
  logic [7:0]       ch_idx;

  logic             in_valid16, in_ready16, out_valid16, out_ready16;
  logic [KW-1:0]    win16, wgt16;
  logic [15:0]      bias16, result16;
  logic [7:0]       ch_idx16;

  conv_mc_acc #(.DATA_W(DATA_W), .KERNEL(KERNEL), .IN_CH(IN_CH), .ACC_W(ACC_W)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .win_i(win), .wgt_i(wgt), .bias_i(bias),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .ch_idx_o(ch_idx)
  );

  conv_mc_acc #(.DATA_W(DATA_W), .KERNEL(KERNEL), .IN_CH(IN_CH), .ACC_W(16)) dut16 (
    .clk_i(clk), .rst_n(rst_n),
    .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .win_i(win16), .wgt_i(wgt16), .bias_i(bias16),
    .out_valid_o(out_valid16), .out_ready_i(out_ready16),
    .result_o(result16), .ch_idx_o(ch_idx16)
  );

  int     n_vec  = 0;
  int     n_fail = 0;
  longint exp_q[$];
  int     model_ch  = 0;
  longint model_sum = 0;
  longint last_exp  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dot_ref(input logic [KW-1:0] w_in, input logic [KW-1:0] k_in);
    longint s;
    logic [DATA_W-1:0]        p;
    logic signed [DATA_W-1:0] c;
    s = 0;
    for (int t = 0; t < KERNEL; t++) begin
      p = w_in[(KERNEL-1-t)*DATA_W +: DATA_W];
      c = k_in[(KERNEL-1-t)*DATA_W +: DATA_W];
      s += longint'(p) * longint'(c);
    end
    return s;
  endfunction

  // Reduce an exact sum to a signed w-bit value, with optional clamp at zero.
  function automatic longint wrap_acc(input longint v, input int w, input bit relu);
    longint one, m;
    one = 1;
    m = v & ((one << w) - 1);
    if (m[w-1]) m = m - (one << w);
    if (relu && m < 0) m = 0;
    return m;
  endfunction

  function automatic logic [KW-1:0] rand_vec();
    return KW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic model_beat(input logic [KW-1:0] w_in, input logic [KW-1:0] k_in,
                            input logic [ACC_W-1:0] b_in, output bit was_last);
    if (model_ch == 0) model_sum = longint'($signed(b_in));
    model_sum += dot_ref(w_in, k_in);
    was_last = (model_ch == IN_CH - 1);
    if (was_last) begin
      last_exp = wrap_acc(model_sum, ACC_W, RELU);
      exp_q.push_back(last_exp);
      model_ch = 0;
    end else begin
      model_ch++;
    end
  endtask

  // Called just after a falling edge; returns just after the next falling
  // edge that follows acceptance.
  task automatic send_beat(input logic [KW-1:0] w_in, input logic [KW-1:0] k_in,
                           input logic [ACC_W-1:0] b_in);
    int waited;
    bit was_last;
    waited   = 0;
    in_valid = 1'b1;
    win      = w_in;
    wgt      = k_in;
    bias     = b_in;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      check("ch_idx_beat", ch_idx, model_ch);
      model_beat(w_in, k_in, b_in, was_last);
      @(negedge clk);
      in_valid = 1'b0;
      win      = rand_vec();
      wgt      = rand_vec();
      bias     = $urandom;
      if (was_last) check("latency_valid", out_valid, 1);
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    win      = rand_vec();
    wgt      = rand_vec();
    bias     = $urandom;
    check("ch_idx_idle", ch_idx, model_ch);
    @(negedge clk);
  endtask

  // Monitor: pops one expected result per output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_result", out_valid, 0);
        else check("result", longint'($signed(result)), exp_q.pop_front());
      end
    end
  end

  initial begin
    int waited;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    win         = '0;
    wgt         = '0;
    bias        = '0;
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    win16       = '0;
    wgt16       = '0;
    bias16      = '0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ch_idx", ch_idx, 0);
    check("rst_result", result, 0);
    check("rst16_result", result16, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // All-ones window and weights, zero bias.
    repeat (IN_CH) send_beat({KERNEL{8'h01}}, {KERNEL{8'h01}}, 32'd0);
    idle_cycle();

    // Maximum pixel times most negative weight, bias 5.
    repeat (IN_CH) send_beat({KERNEL{8'hFF}}, {KERNEL{8'h80}}, 32'd5);
    idle_cycle();

    // Downstream stall: result holds, no new beats taken.
    out_ready = 1'b0;
    repeat (IN_CH) send_beat(rand_vec(), rand_vec(), $urandom);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      win      = rand_vec();
      wgt      = rand_vec();
      bias     = $urandom;
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", longint'($signed(result)), last_exp);
      check("stall_ch_idx", ch_idx, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", out_valid, 0);
    check("stall_release_ch_idx", ch_idx, 0);

    // Reset in the middle of a result.
    repeat (2) send_beat(rand_vec(), rand_vec(), $urandom);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    model_ch  = 0;
    model_sum = 0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_ch_idx", ch_idx, 0);
    check("midrst_out_valid", out_valid, 0);
    repeat (IN_CH) send_beat(rand_vec(), '0, 32'd10);
    idle_cycle();

    // 16-bit accumulator wrap: three beats of dot 32767.
    win16 = {8'd255, 8'd255, 8'd127, {(KERNEL-3){8'd0}}};
    wgt16 = {8'd127, 8'd1,   8'd1,   {(KERNEL-3){8'd0}}};
    for (int b = 0; b < IN_CH; b++) begin
      in_valid16 = 1'b1;
      check("w16_ch_idx", ch_idx16, b);
      @(negedge clk);
    end
    in_valid16 = 1'b0;
    check("w16_valid", out_valid16, 1);
    check("w16_result", longint'($signed(result16)),
          wrap_acc(IN_CH * dot_ref(win16, wgt16), 16, RELU));
    @(negedge clk);
    check("w16_release", out_valid16, 0);

    // Randomly gated beats with downstream always ready.
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 1) == 1) send_beat(rand_vec(), rand_vec(), $urandom);
      else idle_cycle();
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      idle_cycle();
      waited++;
    end
    check("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
